rv_regfile_mp: RTL and testbench
================================

Name: rv_regfile_mp

Overview:
- Parametrised multi-port integer register file for the RVX core: configurable width, depth and read-port count, with two write ports.
- Provides same-cycle write-to-read forwarding and a per-register pending-write scoreboard, so the issue stage can detect RAW hazards on long-latency results.
- Sits between decode/issue (read, allocate) and writeback (two retire lanes).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; register count is 2**ADDR_W
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never pending

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active low
we0  in  1  write enable, lane 0
waddr0  in  ADDR_W  write address, lane 0
wdata0  in  DATA_W  write data, lane 0
we1  in  1  write enable, lane 1 (higher priority)
waddr1  in  ADDR_W  write address, lane 1
wdata1  in  DATA_W  write data, lane 1
raddr  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W], combinational
rd_busy  out  NRD  port k address has an unresolved pending write
alloc_v  in  1  mark register alloc_addr pending (issue of a long-latency op)
alloc_addr  in  ADDR_W  register to mark pending
pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all pending bits 0, pend_cnt=0. rdata and rd_busy follow combinationally (all 0). Reset mid-operation discards all in-flight writes and allocations.
- Write: on posedge, when weN=1, reg[waddrN] <= wdataN.
  - If we0 and we1 target the same address, lane 1 data is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read, per port k, combinational, in priority order:
  - address 0 with ZERO_REG=1 -> 0
  - else we1 && waddr1==addr -> wdata1
  - else we0 && waddr0==addr -> wdata0
  - else reg[addr]
- Scoreboard update, on posedge:
  - A write on either lane clears pend[waddr].
  - alloc_v=1 sets pend[alloc_addr].
  - Allocation and write to the same address in the same cycle: the set wins (new producer), so the bit ends at 1.
  - alloc_v to address 0 with ZERO_REG=1 is ignored.
- rd_busy[k] = pend[addr_k] && no same-cycle write to addr_k. A forwarded value clears busy the same cycle. Address 0 with ZERO_REG=1 is never busy.
- pend_cnt is a registered popcount of pend, updated in the same edge as pend; range 0..2**ADDR_W.
- Latency:
  - write-to-read: 0 cycles (forwarded), then from storage the next cycle
  - alloc-to-busy: 1 cycle
- No handshake/backpressure; the caller guarantees at most one alloc per cycle.

Optional Feature:
- Macro RV_REGFILE_DUMP_EN.
- When defined: extra output rf_dump, width (2**ADDR_W)*DATA_W, register i at [i*DATA_W +: DATA_W]. It carries storage contents (not forwarded), for testbench/debug observation; register 0 reads 0 when ZERO_REG=1.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then read: rst=0 for 2 cycles, raddr={5,0} -> rdata all 0, rd_busy=0, pend_cnt=0.
- Forwarding and storage: we0=1, waddr0=3, wdata0=0xDEADBEEF, raddr port0=3 in the same cycle -> rdata0=0xDEADBEEF; next cycle with we0=0 -> still 0xDEADBEEF from storage.
- Lane conflict: we0 (addr 7, 0x11) and we1 (addr 7, 0x22) in the same cycle -> forwarded 0x22; next cycle reg7=0x22.
- Zero register: we1 to addr 0 with 0xFFFF, plus alloc_v to addr 0 -> rdata for addr 0 =0, rd_busy=0, pend_cnt unchanged.
- Scoreboard: alloc_v addr 9 -> next cycle rd_busy=1 for port reading 9, pend_cnt=1. Then we0 to addr 9 with 0x5A -> busy=0 that cycle, rdata=0x5A; next cycle pend_cnt=0. Then alloc_v+we1 to addr 9 in the same cycle -> pend stays 1, pend_cnt=1.
- Async reset mid-op: alloc regs 1..4, write reg2=0x77, assert rst between edges -> pend_cnt=0, reg2=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_regfile_mp.sv
// Multi-port register file: two write lanes, NRD combinational read ports with
// write forwarding, and a pending-write scoreboard. Define RV_REGFILE_DUMP_EN for rf_dump.
module rv_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    alloc_v,
    input  logic [ADDR_W-1:0]       alloc_addr,
    output logic [ADDR_W:0]         pend_cnt
`ifdef RV_REGFILE_DUMP_EN
    ,
    output logic [(2**ADDR_W)*DATA_W-1:0] rf_dump
`endif
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0]             regs_reg [NREG];
    logic [NREG-1:0]               pend_reg;
    logic [NREG-1:0]               pend_next;
    logic [NREG-1:0]               wr_en;
    logic [NREG-1:0][DATA_W-1:0]   wr_data;
    logic [ADDR_W:0]               pend_pop;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic hit0, hit1, hit_alloc;
        assign hit0      = we0 && (waddr0 == ADDR_W'(gi));
        assign hit1      = we1 && (waddr1 == ADDR_W'(gi));
        assign hit_alloc = alloc_v && (alloc_addr == ADDR_W'(gi));
        // Lane 1 wins a same-address collision.
        assign wr_data[gi] = hit1 ? wdata1 : wdata0;

        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign wr_en[gi]     = 1'b0;
            assign pend_next[gi] = 1'b0;
        end else begin : g_norm
            assign wr_en[gi]     = hit0 || hit1;
            // A new allocation overrides a retiring write to the same register.
            assign pend_next[gi] = hit_alloc || (pend_reg[gi] && !(hit0 || hit1));
        end
    end

    always_comb begin
        pend_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_pop = pend_pop + (ADDR_W+1)'(pend_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
            pend_reg <= '0;
            pend_cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= wr_data[i];
                end
            end
            pend_reg <= pend_next;
            pend_cnt <= pend_pop;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_zero, fw0, fw1;
        assign rd_addr = raddr[gi*ADDR_W +: ADDR_W];
        assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);
        assign fw1     = we1 && (waddr1 == rd_addr);
        assign fw0     = we0 && (waddr0 == rd_addr);
        assign rdata[gi*DATA_W +: DATA_W] = rd_zero ? '0 :
                                            fw1     ? wdata1 :
                                            fw0     ? wdata0 :
                                                      regs_reg[rd_addr];
        // A value forwarded this cycle resolves the hazard immediately.
        assign rd_busy[gi] = !rd_zero && pend_reg[rd_addr] && !fw1 && !fw0;
    end

`ifdef RV_REGFILE_DUMP_EN
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dump
        assign rf_dump[gi*DATA_W +: DATA_W] = regs_reg[gi];
    end
`endif

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Randomized and directed bench for rv_regfile_mp against an array-based
// reference model of storage, forwarding and the pending scoreboard.
module tb_rv_regfile_mp;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NREG = 2**AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1, alloc_v;
    logic [AW-1:0]     waddr0, waddr1, alloc_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rd_busy;
    logic [AW:0]       pend_cnt;
`ifdef RV_REGFILE_DUMP_EN
    logic [NREG*DW-1:0] rf_dump;
`endif

    rv_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .alloc_v(alloc_v), .alloc_addr(alloc_addr), .pend_cnt(pend_cnt)
`ifdef RV_REGFILE_DUMP_EN
        , .rf_dump(rf_dump)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] m_mem [NREG];
    bit            m_pend [NREG];
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0)                   return '0;
        if (we1 && waddr1 == a)       return wdata1;
        if (we0 && waddr0 == a)       return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if ((we1 && waddr1 == a) || (we0 && waddr0 == a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
        if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
        if (we0) m_pend[waddr0] = 1'b0;
        if (we1) m_pend[waddr1] = 1'b0;
        if (alloc_v && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = raddr[k*AW +: AW];
            check($sformatf("%s_rdata%0d", tag, k), 64'(rdata[k*DW +: DW]), 64'(exp_rdata(a)));
            check($sformatf("%s_busy%0d", tag, k), 64'(rd_busy[k]), 64'(exp_busy(a)));
        end
        check({tag, "_pend_cnt"}, 64'(pend_cnt), 64'(exp_cnt()));
    endtask

    task automatic set_idle();
        we0 = 0; we1 = 0; alloc_v = 0;
        waddr0 = '0; waddr1 = '0; alloc_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic step(input string tag);
        #1 check_outputs(tag);
        $display("txn %-8s we0=%0d a0=%0d we1=%0d a1=%0d alloc=%0d/%0d rd=%0d,%0d cnt=%0d",
                 tag, we0, waddr0, we1, waddr1, alloc_v, alloc_addr,
                 raddr[0 +: AW], raddr[AW +: AW], pend_cnt);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        set_idle();
        set_rd(5, 0);
        rst = 0;
        repeat (2) @(negedge clk);
        #1 check_outputs("reset");
        check("reset_rdata_const", 64'(rdata), 64'd0);
        @(negedge clk);
        rst = 1;

        // Forwarding then storage
        we0 = 1; waddr0 = 3; wdata0 = 32'hDEADBEEF; set_rd(3, 0);
        #1 check("fwd_const", 64'(rdata[0 +: DW]), 64'hDEADBEEF);
        step("fwd");
        set_idle();
        #1 check("store_const", 64'(rdata[0 +: DW]), 64'hDEADBEEF);
        step("store");

        // Lane conflict
        we0 = 1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22; set_rd(7, 3);
        #1 check("conf_fwd_const", 64'(rdata[0 +: DW]), 64'h22);
        step("conflict");
        set_idle();
        #1 check("conf_store_const", 64'(rdata[0 +: DW]), 64'h22);
        step("conf_st");

        // Zero register
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF; alloc_v = 1; alloc_addr = 0; set_rd(0, 7);
        step("zero");
        set_idle();
        #1 check("zero_rdata_const", 64'(rdata[0 +: DW]), 64'd0);
        check("zero_cnt_const", 64'(pend_cnt), 64'd0);
        step("zero_st");

        // Scoreboard
        alloc_v = 1; alloc_addr = 9; set_rd(9, 3);
        step("alloc9");
        set_idle();
        #1 check("sb_busy_const", 64'(rd_busy[0]), 64'd1);
        check("sb_cnt_const", 64'(pend_cnt), 64'd1);
        step("busy9");
        we0 = 1; waddr0 = 9; wdata0 = 32'h5A;
        #1 check("sb_fwd_busy_const", 64'(rd_busy[0]), 64'd0);
        check("sb_fwd_data_const", 64'(rdata[0 +: DW]), 64'h5A);
        step("wr9");
        set_idle();
        #1 check("sb_clear_cnt_const", 64'(pend_cnt), 64'd0);
        step("clr9");
        alloc_v = 1; alloc_addr = 9; we1 = 1; waddr1 = 9; wdata1 = 32'h66;
        step("allocwr9");
        set_idle();
        #1 check("sb_setwins_const", 64'(pend_cnt), 64'd1);
        step("set9");

        // Async reset mid-cycle
        for (int r = 1; r <= 4; r++) begin
            set_idle();
            alloc_v = 1; alloc_addr = AW'(r);
            step("allocN");
        end
        set_idle();
        we0 = 1; waddr0 = 2; wdata0 = 32'h77;
        step("wr2");
        set_idle(); set_rd(2, 4);
        #1 check("pre_rst_const", 64'(rdata[0 +: DW]), 64'h77);
        #1 rst = 0;
        #1 check("arst_cnt", 64'(pend_cnt), 64'd0);
        check("arst_reg2", 64'(rdata[0 +: DW]), 64'd0);
        check("arst_busy", 64'(rd_busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1;

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            we0        = ($urandom_range(0, 1) == 1);
            we1        = ($urandom_range(0, 2) == 0);
            alloc_v    = ($urandom_range(0, 2) == 0);
            waddr0     = rand_addr();
            waddr1     = rand_addr();
            alloc_addr = rand_addr();
            wdata0     = $urandom;
            wdata1     = $urandom;
            set_rd(rand_addr(), rand_addr());
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
